// File: rtl/xy_flit_distributor_pkg.sv
// +----------------------------------------------------------------------------+
// | Package     : xy_flit_distributor_pkg                                      |
// | Description : Shared flit format, flit-type codes, output-port enum and    |
// |               distributor FSM state type for the XY flit distributor.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Flit layout (FLIT_SIZE = 32):
//   [31:30] flit type (HEAD/BODY/TAIL/SINGLE)
//   [11:8]  CMP field (manhattan distance, reductor priority)
//   [7:4]   destination y
//   [3:0]   destination x
//   other bits are payload and pass through untouched.
`default_nettype none

package xy_flit_distributor_pkg;

  localparam int FLIT_SIZE  = 32;
  localparam int HEADER_LEN = 2;
  localparam int TYPE_POS   = FLIT_SIZE - HEADER_LEN;
  localparam int COORD_LEN  = 4;
  localparam int DST_X_POS  = 0;
  localparam int DST_Y_POS  = 4;
  localparam int CMP_POS    = 8;
  localparam int CMP_LEN    = 4;
  localparam int NUM_DIR    = 5;
  localparam int CNT_W      = 16;

  localparam logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'b00;
  localparam logic [HEADER_LEN-1:0] BODY_FLIT   = 2'b01;
  localparam logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'b10;
  localparam logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b11;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_EAST  = 3'd1,
    PORT_WEST  = 3'd2,
    PORT_NORTH = 3'd3,
    PORT_SOUTH = 3'd4
  } port_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } dist_state_e;

  // HEAD and SINGLE flits carry a route; BODY and TAIL follow a lock.
  function automatic logic is_route_type(input logic [HEADER_LEN-1:0] t);
    return (t == HEAD_FLIT) || (t == SINGLE_FLIT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/xy_route_compute.sv
// +----------------------------------------------------------------------------+
// | Module      : xy_route_compute                                             |
// | Description : Combinational XY (dimension-ordered) route computation and   |
// |               CMP (remaining hop count) rewrite for a head flit.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports:
//   dst_x, dst_y  in   destination coordinates from the head flit
//   cmp_in        in   incoming CMP field
//   port          out  selected output port (X first, then Y, else LOCAL)
//   cmp_out       out  rewritten CMP: 0 for LOCAL, else cmp_in-1 saturating at 0
`default_nettype none

module xy_route_compute
  import xy_flit_distributor_pkg::*;
#(
  parameter logic [COORD_LEN-1:0] LOCAL_X = '0,
  parameter logic [COORD_LEN-1:0] LOCAL_Y = '0
) (
  input  logic [COORD_LEN-1:0] dst_x,
  input  logic [COORD_LEN-1:0] dst_y,
  input  logic [CMP_LEN-1:0]   cmp_in,
  output port_e                port,
  output logic [CMP_LEN-1:0]   cmp_out
);

  always_comb begin
    port = PORT_LOCAL;
    if (dst_x > LOCAL_X) begin
      port = PORT_EAST;
    end else if (dst_x < LOCAL_X) begin
      port = PORT_WEST;
    end else if (dst_y > LOCAL_Y) begin
      port = PORT_NORTH;
    end else if (dst_y < LOCAL_Y) begin
      port = PORT_SOUTH;
    end

    // Delivered locally: no hops remain, so priority distance is zero.
    cmp_out = '0;
    if ((port != PORT_LOCAL) && (cmp_in != '0)) begin
      cmp_out = cmp_in - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/xy_flit_distributor.sv
// +----------------------------------------------------------------------------+
// | Module      : xy_flit_distributor                                          |
// | Description : 1-to-5 wormhole demux at a router input. Buffers incoming    |
// |               flits, routes heads with XY routing, rewrites the head CMP   |
// |               field and locks the chosen output until the tail passes.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   in          incoming flit, written when in_valid (ignored while full)
//   in_avail    input FIFO not full
//   out         flit bus replicated on all NUM_DIR slices (slice p = port p)
//   out_valid   one-hot (or zero) write strobe per output port
//   out_avail   per-port downstream queue not full
//   pkt_cnt     heads/singles forwarded per port (16 bits each, wrapping)
//   drop_cnt    orphan body/tail flits discarded (16 bits, wrapping)
// Build option:
//   DISTRIBUTOR_STATS_EN  when defined, pkt_cnt/drop_cnt ports and counters exist.
`default_nettype none

module xy_flit_distributor
  import xy_flit_distributor_pkg::*;
#(
  parameter logic [COORD_LEN-1:0] LOCAL_X        = '0,
  parameter logic [COORD_LEN-1:0] LOCAL_Y        = '0,
  parameter int                   FIFO_DEPTH_LOG = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FLIT_SIZE-1:0]         in,
  input  logic                         in_valid,
  output logic                         in_avail,
  output logic [FLIT_SIZE*NUM_DIR-1:0] out,
  output logic [NUM_DIR-1:0]           out_valid,
  input  logic [NUM_DIR-1:0]           out_avail
`ifdef DISTRIBUTOR_STATS_EN
  ,
  output logic [NUM_DIR*CNT_W-1:0]     pkt_cnt,
  output logic [CNT_W-1:0]             drop_cnt
`endif
);

  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG;
  localparam int PTR_W = FIFO_DEPTH_LOG + 1;

  // Input FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [FLIT_SIZE-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                 empty, full, push, pop;
  logic [FLIT_SIZE-1:0] head_flit;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
  assign in_avail  = !full;
  assign push      = in_valid && !full;
  assign head_flit = mem_q[rd_ptr_q[PTR_W-2:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-2:0]] <= in;
    end
  end

  // Route of the flit at the FIFO head.
  port_e              route_port;
  logic [CMP_LEN-1:0] route_cmp;

  xy_route_compute #(
    .LOCAL_X (LOCAL_X),
    .LOCAL_Y (LOCAL_Y)
  ) u_route (
    .dst_x   (head_flit[DST_X_POS +: COORD_LEN]),
    .dst_y   (head_flit[DST_Y_POS +: COORD_LEN]),
    .cmp_in  (head_flit[CMP_POS +: CMP_LEN]),
    .port    (route_port),
    .cmp_out (route_cmp)
  );

  dist_state_e          state_q, state_d;
  port_e                lock_port_q, lock_port_d;
  logic [HEADER_LEN-1:0] head_type;
  logic                 is_hdr, drop, fwd;
  port_e                target;
  logic [NUM_DIR-1:0]   target_oh;
  logic [FLIT_SIZE-1:0] out_flit;

  // A HEAD/SINGLE at the head is always routed afresh, even in BUSY: a
  // packet missing its tail is closed implicitly by the next head.
  always_comb begin
    head_type = head_flit[TYPE_POS +: HEADER_LEN];
    is_hdr    = is_route_type(head_type);
    target    = is_hdr ? route_port : lock_port_q;
    out_flit  = head_flit;
    if (is_hdr) begin
      out_flit[CMP_POS +: CMP_LEN] = route_cmp;
    end
  end

  generate
    for (genvar p = 0; p < NUM_DIR; p++) begin : g_port
      assign target_oh[p]                  = (target == port_e'(p));
      assign out_valid[p]                  = fwd && target_oh[p];
      assign out[p*FLIT_SIZE +: FLIT_SIZE] = out_flit;
    end
  endgenerate

  // Orphan body/tail flits (no open packet) are popped without a strobe.
  assign drop = !empty && !is_hdr && (state_q == ST_IDLE);
  assign fwd  = !empty && !drop && |(target_oh & out_avail);
  assign pop  = fwd || drop;

  always_comb begin
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    state_d     = state_q;
    lock_port_d = lock_port_q;
    if (fwd) begin
      case (head_type)
        HEAD_FLIT: begin
          state_d     = ST_BUSY;
          lock_port_d = route_port;
        end
        SINGLE_FLIT, TAIL_FLIT: state_d = ST_IDLE;
        default:                state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= ST_IDLE;
      lock_port_q <= PORT_LOCAL;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      lock_port_q <= lock_port_d;
    end
  end

`ifdef DISTRIBUTOR_STATS_EN
  logic [CNT_W-1:0] pkt_cnt_q [NUM_DIR];
  logic [CNT_W-1:0] pkt_cnt_d [NUM_DIR];
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    for (int p = 0; p < NUM_DIR; p++) begin
      pkt_cnt_d[p] = pkt_cnt_q[p] + CNT_W'(fwd && is_hdr && target_oh[p]);
    end
    drop_cnt_d = drop_cnt_q + CNT_W'(drop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_DIR; p++) begin
        pkt_cnt_q[p] <= '0;
      end
      drop_cnt_q <= '0;
    end else begin
      for (int p = 0; p < NUM_DIR; p++) begin
        pkt_cnt_q[p] <= pkt_cnt_d[p];
      end
      drop_cnt_q <= drop_cnt_d;
    end
  end

  generate
    for (genvar p = 0; p < NUM_DIR; p++) begin : g_pkt_cnt
      assign pkt_cnt[p*CNT_W +: CNT_W] = pkt_cnt_q[p];
    end
  endgenerate

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

`default_nettype wire
